// File: rtl/rv_mc_sequencer.sv
// Multicycle control sequencer for the RISC-V datapath. Handshakes with
// instruction/data memory, guards memory waits with a watchdog, traps on
// illegal opcodes or bus timeouts and counts retired instructions.
module rv_mc_sequencer #(
  parameter int XLEN        = 64,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             ir_load_o,
  output logic             pc_write_o,
  output logic             pc_source_o,
  output logic             rega_write_o,
  output logic             regb_write_o,
  output logic             aluout_write_o,
  output logic             mdr_load_o,
  output logic             reg_write_o,
  output logic             mux_data_sel_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [2:0]       imm_sel_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_MEM, S_BRANCH, S_JAL, S_LUI, S_TRAP
  } state_e;

  // Only the doubleword (64) or word (32) load/store width is legal.
  localparam logic [2:0] LS_F3 = (XLEN == 64) ? 3'b011 : 3'b010;
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       waiting, acked, timeout;
  logic [2:0] imm_fmt;
  logic       unused_instr_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  // Watchdog: detect memory-wait states, their completion and expiry.
  always_comb begin
    waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    acked   = ((state_q == S_FETCH) && imem_ack_i) ||
              (((state_q == S_MEM_RD) || (state_q == S_MEM_WR)) && dmem_ack_i);
    timeout = waiting && !acked && (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);
    wait_d  = (waiting && !acked && !timeout && (MEM_TIMEOUT != 0)) ? wait_q + 1'b1 : '0;
  end

  // Immediate format implied by the opcode.
  always_comb begin
    case (opcode)
      7'b0100011: imm_fmt = 3'b001;
      7'b1100011: imm_fmt = 3'b010;
      7'b0110111: imm_fmt = 3'b011;
      7'b1101111: imm_fmt = 3'b100;
      default:    imm_fmt = 3'b000;
    endcase
  end

  // Next-state and trap-cause selection; a timeout overrides everything.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  if (imem_ack_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          7'b0110011: state_d = S_EXEC_R;
          7'b0010011: state_d = (funct3 == 3'b000) ? S_EXEC_I : S_TRAP;
          7'b0000011,
          7'b0100011: state_d = (funct3 == LS_F3) ? S_ADDR : S_TRAP;
          7'b1100011: state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
          7'b0110111: state_d = S_LUI;
          7'b1101111: state_d = S_JAL;
          default:    state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) cause_d = CAUSE_ILLEGAL;
      end
      S_EXEC_R: begin
        if (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b100) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_ADDR:   state_d = instr_i[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (dmem_ack_i) state_d = S_WB_MEM;
      S_MEM_WR: if (dmem_ack_i) state_d = S_FETCH;
      S_EXEC_I, S_WB_MEM, S_BRANCH, S_JAL, S_LUI: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  // State, watchdog, trap cause and retired-instruction counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      cause_q   <= 2'b00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_TRAP)
        instret_q <= instret_q + 1'b1;
    end
  end

  // Control outputs: Moore decode of the state, with ack-qualified strobes;
  // everything is held at 0 while reset is asserted.
  always_comb begin
    imem_req_o     = 1'b0;
    dmem_req_o     = 1'b0;
    dmem_we_o      = 1'b0;
    ir_load_o      = 1'b0;
    pc_write_o     = 1'b0;
    pc_source_o    = 1'b0;
    rega_write_o   = 1'b0;
    regb_write_o   = 1'b0;
    aluout_write_o = 1'b0;
    mdr_load_o     = 1'b0;
    reg_write_o    = 1'b0;
    mux_data_sel_o = 1'b0;
    alu_src_a_o    = 2'b00;
    alu_src_b_o    = 2'b00;
    alu_op_o       = 3'b000;
    imm_sel_o      = 3'b000;
    trap_o         = 1'b0;
    if (rst_ni) begin
      case (state_q)
        S_FETCH: begin
          imem_req_o  = 1'b1;
          ir_load_o   = imem_ack_i;
          pc_write_o  = imem_ack_i;
          alu_src_b_o = 2'b01;
          alu_op_o    = 3'b001;
        end
        S_DECODE: begin
          rega_write_o   = 1'b1;
          regb_write_o   = 1'b1;
          aluout_write_o = 1'b1;
          alu_src_a_o    = 2'b10;
          alu_src_b_o    = 2'b11;
          alu_op_o       = 3'b001;
          imm_sel_o      = imm_fmt;
        end
        S_EXEC_R: begin
          alu_src_a_o = 2'b01;
          reg_write_o = 1'b1;
          case (funct3)
            3'b000:  alu_op_o = instr_i[30] ? 3'b010 : 3'b001;
            3'b111:  alu_op_o = 3'b011;
            3'b100:  alu_op_o = 3'b110;
            default: reg_write_o = 1'b0;
          endcase
        end
        S_EXEC_I, S_ADDR: begin
          alu_src_a_o    = 2'b01;
          alu_src_b_o    = 2'b10;
          alu_op_o       = 3'b001;
          imm_sel_o      = imm_fmt;
          reg_write_o    = (state_q == S_EXEC_I);
          aluout_write_o = (state_q == S_ADDR);
        end
        S_MEM_RD: begin
          dmem_req_o = 1'b1;
          mdr_load_o = dmem_ack_i;
        end
        S_MEM_WR: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = 1'b1;
        end
        S_WB_MEM: begin
          mux_data_sel_o = 1'b1;
          reg_write_o    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o = 2'b01;
          alu_op_o    = 3'b010;
          pc_source_o = 1'b1;
          pc_write_o  = funct3[0] ? !zero_i : zero_i;
        end
        S_JAL: begin
          reg_write_o = 1'b1;
          pc_write_o  = 1'b1;
          pc_source_o = 1'b1;
        end
        S_LUI: begin
          alu_src_a_o = 2'b11;
          alu_src_b_o = 2'b10;
          alu_op_o    = 3'b001;
          imm_sel_o   = imm_fmt;
          reg_write_o = 1'b1;
        end
        S_TRAP:  trap_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign trap_cause_o = cause_q;
  assign instret_o    = instret_q;

endmodule
